// File: rtl/len5_pkg.sv
// Core-wide exception cause codes shared by the memory subsystem.
package len5_pkg;

  localparam int unsigned EXCEPT_CODE_W = 6;

  typedef enum logic [EXCEPT_CODE_W-1:0] {
    E_I_ADDR_MISALIGNED  = 6'h00,
    E_I_ACCESS_FAULT     = 6'h01,
    E_ILLEGAL_INSTR      = 6'h02,
    E_BREAKPOINT         = 6'h03,
    E_LD_ADDR_MISALIGNED = 6'h04,
    E_LD_ACCESS_FAULT    = 6'h05,
    E_ST_ADDR_MISALIGNED = 6'h06,
    E_ST_ACCESS_FAULT    = 6'h07,
    E_ENV_CALL_UMODE     = 6'h08,
    E_ENV_CALL_SMODE     = 6'h09,
    E_ENV_CALL_MMODE     = 6'h0b
  } except_code_t;

endpackage

// File: rtl/memory_pkg.sv
// Request/answer payloads for the core's memory interfaces.
package memory_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned MEM_TAG_W = 8;

  typedef enum logic [1:0] {
    ACC_INSTR = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } acc_type_t;

  typedef enum logic [2:0] {
    LS_BYTE       = 3'd0,
    LS_HALFWORD   = 3'd1,
    LS_WORD       = 3'd2,
    LS_DOUBLEWORD = 3'd3,
    LS_BYTE_U     = 3'd4,
    LS_HALFWORD_U = 3'd5,
    LS_WORD_U     = 3'd6
  } ls_type_t;

  typedef struct packed {
    logic [MEM_TAG_W-1:0] tag;
    acc_type_t            acc_type;
    ls_type_t             ls_type;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      value;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_TAG_W-1:0]   tag;
    acc_type_t              acc_type;
    logic [XLEN-1:0]        value;
    logic                   except_raised;
    len5_pkg::except_code_t except_code;
  } mem_ans_t;

  // Access size in bytes; unsigned variants share the signed sizes.
  function automatic logic [3:0] ls_size(input ls_type_t ls);
    logic [3:0] sz;
    case (ls)
      LS_BYTE, LS_BYTE_U:         sz = 4'd1;
      LS_HALFWORD, LS_HALFWORD_U: sz = 4'd2;
      LS_WORD, LS_WORD_U:         sz = 4'd4;
      default:                    sz = 4'd8;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/fifo_nohs.sv
// Plain circular FIFO without handshake; the parent gates push/pop.
module fifo_nohs #(
  parameter type         DATA_T = logic [7:0],
  parameter int unsigned DEPTH  = 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  logic  push_i,
  input  DATA_T data_i,
  input  logic  pop_i,
  output logic  valid_o,
  output DATA_T data_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  DATA_T            data_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != CNT_W'(DEPTH)) | do_pop);
    head_d  = do_pop ? ptr_inc(head_q) : head_q;
    tail_d  = do_push ? ptr_inc(tail_q) : tail_q;
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (do_push) data_q[tail_q] <= data_i;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = data_q[head_q];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency, in-order memory emulator for the fetch and load/store ports.
module mem_responder
  import memory_pkg::*;
  import len5_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     flush_i,
  input  logic     req_valid_i,
  output logic     req_ready_o,
  input  mem_req_t req_i,
  output logic     ans_valid_o,
  input  logic     ans_ready_i,
  output mem_ans_t ans_o
);

  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned OCC_W = $clog2(OUT_DEPTH + 1);

  logic [7:0]       mem_q [MEM_BYTES];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             kill;
  logic             accept;
  logic             ans_pop;
  logic             pipe_push;
  mem_ans_t         pipe_ans;
  mem_ans_t         eval_ans;
  logic [3:0]       size;
  logic             misaligned;
  logic             out_of_range;
  logic             mem_we;
  logic [AW-1:0]    base;
  logic [XLEN-1:0]  rdata;

  function automatic except_code_t except_code(input acc_type_t acc, input logic mis);
    except_code_t code;
    case (acc)
      ACC_INSTR: code = mis ? E_I_ADDR_MISALIGNED : E_I_ACCESS_FAULT;
      ACC_LOAD:  code = mis ? E_LD_ADDR_MISALIGNED : E_LD_ACCESS_FAULT;
      default:   code = mis ? E_ST_ADDR_MISALIGNED : E_ST_ACCESS_FAULT;
    endcase
    return code;
  endfunction

  assign kill = rst_i | flush_i;

  // Credits: every accepted request owns one output-buffer slot until consumed.
  assign req_ready_o = (occ_q < OCC_W'(OUT_DEPTH)) & ~kill;
  assign accept      = req_valid_i & req_ready_o;
  assign ans_pop     = ans_valid_o & ans_ready_i & ~kill;

  always_comb begin
    occ_d = occ_q;
    if (kill) begin
      occ_d = '0;
    end else if (accept & ~ans_pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (~accept & ans_pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  // Evaluate the request in its accept cycle: checks, read data and answer.
  always_comb begin
    size         = ls_size(req_i.ls_type);
    misaligned   = (req_i.addr & XLEN'(size - 4'd1)) != '0;
    out_of_range = ({1'b0, req_i.addr} + (XLEN + 1)'(size)) > (XLEN + 1)'(MEM_BYTES);
    base         = req_i.addr[AW-1:0];
    rdata        = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (4'(i) < size) rdata[8*i +: 8] = mem_q[base + AW'(i)];
    end

    eval_ans          = '0;
    eval_ans.tag      = req_i.tag;
    eval_ans.acc_type = req_i.acc_type;
    if (misaligned || out_of_range) begin
      eval_ans.except_raised = 1'b1;
      eval_ans.except_code   = except_code(req_i.acc_type, misaligned);
    end else if (req_i.acc_type != ACC_STORE) begin
      eval_ans.value = rdata;
    end

    mem_we = accept & (req_i.acc_type == ACC_STORE) & ~misaligned & ~out_of_range;
  end

  // Array contents survive reset and flush on purpose.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (4'(i) < size) mem_q[base + AW'(i)] <= req_i.value[8*i +: 8];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat_direct
      assign pipe_push = accept;
      assign pipe_ans  = eval_ans;
    end else begin : g_lat_pipe
      localparam int unsigned NSTG = LATENCY - 1;

      logic [NSTG-1:0] pv_q;
      mem_ans_t        pa_q [NSTG];

      always_ff @(posedge clk_i) begin
        if (kill) begin
          pv_q <= '0;
        end else begin
          pv_q[0] <= accept;
          for (int unsigned i = 1; i < NSTG; i++) pv_q[i] <= pv_q[i-1];
        end
      end

      always_ff @(posedge clk_i) begin
        pa_q[0] <= eval_ans;
        for (int unsigned i = 1; i < NSTG; i++) pa_q[i] <= pa_q[i-1];
      end

      assign pipe_push = pv_q[NSTG-1];
      assign pipe_ans  = pa_q[NSTG-1];
    end
  endgenerate

  fifo_nohs #(
    .DATA_T (mem_ans_t),
    .DEPTH  (OUT_DEPTH)
  ) u_out_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (pipe_push & ~flush_i),
    .data_i  (pipe_ans),
    .pop_i   (ans_pop),
    .valid_o (ans_valid_o),
    .data_o  (ans_o)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: reference byte array plus in-order answer queue.
module tb_mem_responder;
  import memory_pkg::*;
  import len5_pkg::*;

  localparam int unsigned MEM_BYTES = 65536;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned OUT_DEPTH = 2;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     flush = 1'b0;
  logic     req_valid = 1'b0;
  logic     req_ready;
  mem_req_t req = '0;
  logic     ans_valid;
  logic     ans_ready;
  mem_ans_t ans;
  logic     rdy_set = 1'b0;
  logic     rnd_bit = 1'b0;
  logic     rand_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_ans_t   sb[$];
  logic [7:0] tags_seen[$];
  logic [7:0] ref_mem [MEM_BYTES];

  assign ans_ready = rand_mode ? rnd_bit : rdy_set;

  mem_responder #(
    .MEM_BYTES (MEM_BYTES),
    .LATENCY   (LATENCY),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_i       (req),
    .ans_valid_o (ans_valid),
    .ans_ready_i (ans_ready),
    .ans_o       (ans)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  // Scoreboard: consume/compare first, then model any request accepted at the coming edge.
  always @(negedge clk) begin
    mem_ans_t    e;
    mem_ans_t    got;
    int unsigned sz;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (ans_valid && ans_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_answer got=%h (no answer outstanding)", ans);
        end else begin
          e   = sb.pop_front();
          got = ans;
          tags_seen.push_back(got.tag);
          if (got !== e) begin
            errors++;
            $display("FAIL answer tag=%0d got=%h exp=%h", e.tag, got, e);
          end
        end
      end
      if (req_valid && req_ready) begin
        case (req.ls_type)
          LS_BYTE, LS_BYTE_U:         sz = 1;
          LS_HALFWORD, LS_HALFWORD_U: sz = 2;
          LS_WORD, LS_WORD_U:         sz = 4;
          default:                    sz = 8;
        endcase
        e          = '0;
        e.tag      = req.tag;
        e.acc_type = req.acc_type;
        if ((req.addr % 64'(sz)) != 0) begin
          e.except_raised = 1'b1;
          e.except_code   = except_code_t'(6'((req.acc_type == ACC_INSTR) ? 0 :
                                              (req.acc_type == ACC_LOAD) ? 4 : 6));
        end else if (({1'b0, req.addr} + 65'(sz)) > 65'(MEM_BYTES)) begin
          e.except_raised = 1'b1;
          e.except_code   = except_code_t'(6'((req.acc_type == ACC_INSTR) ? 1 :
                                              (req.acc_type == ACC_LOAD) ? 5 : 7));
        end else if (req.acc_type == ACC_STORE) begin
          for (int unsigned i = 0; i < sz; i++)
            ref_mem[int'(req.addr[15:0]) + int'(i)] = req.value[8*i +: 8];
        end else begin
          for (int unsigned i = 0; i < sz; i++)
            e.value[8*i +: 8] = ref_mem[int'(req.addr[15:0]) + int'(i)];
        end
        sb.push_back(e);
      end
    end
  end

  // Present one request and hold it until accepted (bounded).
  task automatic send(input logic [7:0] tag, input acc_type_t acc, input ls_type_t ls,
                      input logic [63:0] addr, input logic [63:0] val);
    bit ok = 1'b0;
    req       = '{tag: tag, acc_type: acc, ls_type: ls, addr: addr, value: val};
    req_valid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept tag=%0d accepted=0 required=1", tag);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !ans_valid) done = 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ans_valid !== 1'b0) begin errors++; $display("FAIL reset_ans_valid got=%b exp=0", ans_valid); end
    checks++;
    if (ans !== '0) begin errors++; $display("FAIL reset_ans got=%h exp=0", ans); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    int lat = 0;
    rdy_set = 1'b1;
    send(8'd1, ACC_STORE, LS_DOUBLEWORD, 64'h100, 64'h1122334455667788);
    wait_drain("single_store");
    send(8'd2, ACC_LOAD, LS_WORD, 64'h104, 64'h0);
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (ans_valid) lat = k;
    end
    checks++;
    if (lat != LATENCY) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, LATENCY); end
    checks++;
    if (ans.value !== 64'h11223344) begin errors++; $display("FAIL single_value got=%h exp=11223344", ans.value); end
    checks++;
    if (ans.except_raised !== 1'b0) begin errors++; $display("FAIL single_except got=%b exp=0", ans.except_raised); end
    @(posedge clk);
    #1;
    wait_drain("single");
  endtask

  task automatic test_backpressure;
    int next = 1;
    int cyc  = 0;
    rdy_set = 1'b1;
    send(8'd5, ACC_STORE, LS_DOUBLEWORD, 64'h200, 64'hCAFEF00DDEADBEEF);
    send(8'd6, ACC_STORE, LS_DOUBLEWORD, 64'h208, 64'h0123456789ABCDEF);
    wait_drain("bp_setup");
    tags_seen.delete();
    rdy_set   = 1'b0;
    req_valid = 1'b1;
    req = '{tag: 8'(next), acc_type: ACC_INSTR, ls_type: LS_WORD, addr: 64'h200, value: 64'h0};
    repeat (6) begin
      @(negedge clk);
      if (req_ready) next++;
      @(posedge clk);
      #1;
      req = '{tag: 8'(next), acc_type: ACC_INSTR, ls_type: LS_WORD,
              addr: 64'h200 + 64'(4 * (next - 1)), value: 64'h0};
    end
    checks++;
    if (next - 1 != OUT_DEPTH) begin errors++; $display("FAIL bp_accepted got=%0d exp=%0d", next - 1, OUT_DEPTH); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", req_ready); end
    @(posedge clk);
    #1 rdy_set = 1'b1;
    while (next <= 4 && cyc < 40) begin
      @(negedge clk);
      if (req_ready) next++;
      @(posedge clk);
      #1;
      cyc++;
      req = '{tag: 8'(next), acc_type: ACC_INSTR, ls_type: LS_WORD,
              addr: 64'h200 + 64'(4 * (next - 1)), value: 64'h0};
    end
    req_valid = 1'b0;
    wait_drain("bp");
    checks++;
    if (tags_seen.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", tags_seen.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= tags_seen.size() || tags_seen[i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i,
                 (i < tags_seen.size()) ? tags_seen[i] : 8'hff, i + 1);
      end
    end
  endtask

  task automatic test_misaligned;
    rdy_set = 1'b1;
    send(8'd10, ACC_INSTR, LS_WORD, 64'h102, 64'h0);
    send(8'd11, ACC_LOAD, LS_WORD, 64'h200, 64'h0);
    send(8'd12, ACC_STORE, LS_HALFWORD, 64'h205, 64'h1234);
    send(8'd13, ACC_LOAD, LS_HALFWORD_U, 64'h206, 64'h0);
    wait_drain("misaligned");
  endtask

  task automatic test_fault;
    rdy_set = 1'b1;
    send(8'd20, ACC_STORE, LS_BYTE, 64'h0, 64'h5A);
    send(8'd21, ACC_LOAD, LS_DOUBLEWORD, 64'(MEM_BYTES - 4), 64'h0);
    send(8'd22, ACC_LOAD, LS_DOUBLEWORD, 64'(MEM_BYTES), 64'h0);
    send(8'd23, ACC_STORE, LS_BYTE, 64'(MEM_BYTES), 64'hA5);
    send(8'd24, ACC_LOAD, LS_BYTE, 64'h0, 64'h0);
    send(8'd25, ACC_INSTR, LS_WORD, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    send(8'd26, ACC_STORE, LS_WORD, 64'(MEM_BYTES - 4), 64'h87654321);
    send(8'd27, ACC_LOAD, LS_WORD_U, 64'(MEM_BYTES - 4), 64'h0);
    wait_drain("fault");
  endtask

  task automatic test_flush;
    rdy_set = 1'b1;
    send(8'd30, ACC_STORE, LS_WORD, 64'h300, 64'hA1B2C3D4);
    wait_drain("flush_setup");
    rdy_set = 1'b0;
    send(8'd31, ACC_STORE, LS_WORD, 64'h308, 64'h55667788);
    send(8'd32, ACC_LOAD, LS_WORD, 64'h300, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    flush     = 1'b1;
    req_valid = 1'b1;
    req = '{tag: 8'd33, acc_type: ACC_STORE, ls_type: LS_WORD, addr: 64'h300, value: 64'hFFFFFFFF};
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_during got=%b exp=0", req_ready); end
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ans_valid !== 1'b0) begin errors++; $display("FAIL flush_ans_valid got=%b exp=0", ans_valid); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_req_ready got=%b exp=1", req_ready); end
    @(posedge clk);
    #1;
    send(8'd34, ACC_LOAD, LS_WORD, 64'h308, 64'h0);
    send(8'd35, ACC_LOAD, LS_WORD, 64'h300, 64'h0);
    rdy_set = 1'b1;
    wait_drain("flush");
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    rdy_set = 1'b0;
    send(8'd40, ACC_LOAD, LS_WORD, 64'h300, 64'h0);
    send(8'd41, ACC_LOAD, LS_WORD, 64'h308, 64'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ans_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ans_valid got=%b exp=0", ans_valid); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready got=%b exp=1", req_ready); end
    rdy_set = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (ans_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rstmid_stale got=%0d exp=0", seen); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int unsigned off;
    ls_type_t    ls;
    rdy_set = 1'b1;
    send(8'd50, ACC_STORE, LS_WORD, 64'h400, 64'h0BADF00D);
    send(8'd51, ACC_LOAD, LS_WORD, 64'h400, 64'h0);
    send(8'd52, ACC_LOAD, LS_HALFWORD_U, 64'h402, 64'h0);
    send(8'd53, ACC_STORE, LS_BYTE, 64'h401, 64'h77);
    send(8'd54, ACC_LOAD, LS_WORD, 64'h400, 64'h0);
    for (int i = 0; i < 9; i++)
      send(8'(60 + i), ACC_STORE, LS_DOUBLEWORD, 64'h400 + 64'(8 * i), {$urandom, $urandom});
    wait_drain("b2b_fill");
    rand_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ls  = ls_type_t'($urandom_range(0, 6));
      off = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) off = off & ~((32'd1 << (int'(ls) % 4)) - 32'd1);
      send(8'(100 + i), acc_type_t'($urandom_range(0, 2)), ls, 64'h400 + 64'(off), {$urandom, $urandom});
    end
    rand_mode = 1'b0;
    wait_drain("b2b");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_misaligned();
    test_fault();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
